// File: rtl/sargantana_icache_pkg.sv
// Shared types for the I-cache tag controller slice.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package sargantana_icache_pkg;

  localparam int ICACHE_N_WAY   = 4;
  localparam int TAG_DEPTH      = 128;
  localparam int TAG_ADDR_WIDHT = $clog2(TAG_DEPTH);
  localparam int TAG_WIDHT      = 27;
  localparam int RR_WIDTH       = $clog2(ICACHE_N_WAY);

  typedef logic [ICACHE_N_WAY-1:0] way_oh_t;

  typedef enum logic [2:0] {
    TC_IDLE,
    TC_COMPARE,
    TC_MISS_REQ,
    TC_MISS_WAIT,
    TC_REFILL_WR
  } tag_ctrl_state_t;

  typedef struct packed {
    logic [TAG_WIDHT-1:0]      tag;
    logic [TAG_ADDR_WIDHT-1:0] idx;
  } l2_req_t;

  // Keeps only the lowest set bit of a way vector (zero in, zero out).
  function automatic way_oh_t lowest_one(way_oh_t v);
    way_oh_t r;
    r = '0;
    for (int w = ICACHE_N_WAY - 1; w >= 0; w--) begin
      if (v[w]) begin
        r    = '0;
        r[w] = 1'b1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/sargantana_icache_victim_sel.sv
// Victim way choice: lowest invalid way, else the round-robin way.
// Latency: combinational.
// Backpressure: none; rr_used_o tells the caller to advance its pointer.
module sargantana_icache_victim_sel
  import sargantana_icache_pkg::*;
(
  input  way_oh_t             valid_i,
  input  logic [RR_WIDTH-1:0] rr_i,
  output way_oh_t             victim_o,
  output logic                rr_used_o
);

  // Fill empty ways first; only a full set consumes the round-robin pointer.
  always_comb begin
    rr_used_o = &valid_i;
    victim_o  = lowest_one(~valid_i);
    if (rr_used_o) begin
      victim_o = way_oh_t'(1) << rr_i;
    end
  end

endmodule

// File: rtl/sargantana_icache_tag_ctrl.sv
// Lookup/refill controller in front of the I-cache tag memory: read, compare, miss -> L2 -> tag install.
// Latency: hit/miss known the cycle after accept; refill writes the cycle after a good L2 response.
// Backpressure: lookups accepted only in IDLE without flush; L2 request held until l2_req_ready_i.
module sargantana_icache_tag_ctrl
  import sargantana_icache_pkg::*;
(
  input  logic                                 clk_i,
  input  logic                                 rstn_i,
  input  logic                                 flush_i,
  input  logic                                 lookup_valid_i,
  output logic                                 lookup_ready_o,
  input  logic [TAG_ADDR_WIDHT-1:0]            lookup_idx_i,
  input  logic [TAG_WIDHT-1:0]                 lookup_tag_i,
  output logic                                 hit_o,
  output logic [ICACHE_N_WAY-1:0]              hit_way_o,
  output logic                                 refill_done_o,
  output logic                                 refill_err_o,
  output logic [ICACHE_N_WAY-1:0]              refill_way_o,
  output logic                                 l2_req_valid_o,
  input  logic                                 l2_req_ready_i,
  output logic [TAG_WIDHT+TAG_ADDR_WIDHT-1:0]  l2_req_addr_o,
  input  logic                                 l2_resp_valid_i,
  input  logic                                 l2_resp_err_i,
  output logic [ICACHE_N_WAY-1:0]              tm_req_o,
  output logic                                 tm_we_o,
  output logic                                 tm_vbit_o,
  output logic                                 tm_flush_o,
  output logic [TAG_WIDHT-1:0]                 tm_data_o,
  output logic [TAG_ADDR_WIDHT-1:0]            tm_addr_o,
  input  logic [ICACHE_N_WAY-1:0][TAG_WIDHT-1:0] tm_tag_way_i,
  input  logic [ICACHE_N_WAY-1:0]              tm_vbit_i
);

  tag_ctrl_state_t           state_q, state_d;
  logic [TAG_WIDHT-1:0]      tag_q, tag_d;
  logic [TAG_ADDR_WIDHT-1:0] idx_q, idx_d;
  way_oh_t                   victim_q, victim_d;
  logic [RR_WIDTH-1:0]       rr_q, rr_d;
  logic                      drain_q, drain_d;

  way_oh_t                   hitvec;
  way_oh_t                   victim;
  logic                      rr_used;
  l2_req_t                   l2_req;

  assign tm_flush_o = flush_i;
  assign l2_req     = '{tag: tag_q, idx: idx_q};

  // Per-way tag match against the tag latched at accept.
  always_comb begin
    hitvec = '0;
    for (int w = 0; w < ICACHE_N_WAY; w++) begin
      hitvec[w] = tm_vbit_i[w] & (tm_tag_way_i[w] == tag_q);
    end
  end

  sargantana_icache_victim_sel u_victim_sel (
    .valid_i   (tm_vbit_i),
    .rr_i      (rr_q),
    .victim_o  (victim),
    .rr_used_o (rr_used)
  );

  // State and lookup context registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= TC_IDLE;
      tag_q    <= '0;
      idx_q    <= '0;
      victim_q <= '0;
      rr_q     <= '0;
      drain_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      tag_q    <= tag_d;
      idx_q    <= idx_d;
      victim_q <= victim_d;
      rr_q     <= rr_d;
      drain_q  <= drain_d;
    end
  end

  // Next-state and output decode; drain marks an L2 transaction whose result must be dropped.
  always_comb begin
    state_d        = state_q;
    tag_d          = tag_q;
    idx_d          = idx_q;
    victim_d       = victim_q;
    rr_d           = rr_q;
    drain_d        = drain_q;
    lookup_ready_o = 1'b0;
    hit_o          = 1'b0;
    hit_way_o      = '0;
    refill_done_o  = 1'b0;
    refill_err_o   = 1'b0;
    refill_way_o   = '0;
    l2_req_valid_o = 1'b0;
    l2_req_addr_o  = '0;
    tm_req_o       = '0;
    tm_we_o        = 1'b0;
    tm_vbit_o      = 1'b0;
    tm_data_o      = '0;
    tm_addr_o      = '0;
    case (state_q)
      TC_IDLE: begin
        // Gated by reset so every output reads 0 while reset is held.
        lookup_ready_o = rstn_i & ~flush_i;
        if (lookup_valid_i && lookup_ready_o) begin
          tm_req_o  = '1;
          tm_addr_o = lookup_idx_i;
          tag_d     = lookup_tag_i;
          idx_d     = lookup_idx_i;
          state_d   = TC_COMPARE;
        end
      end
      TC_COMPARE: begin
        state_d = TC_IDLE;
        if (!flush_i) begin
          if (|hitvec) begin
            hit_o     = 1'b1;
            hit_way_o = lowest_one(hitvec);
          end else begin
            victim_d = victim;
            if (rr_used) begin
              rr_d = (rr_q == RR_WIDTH'(ICACHE_N_WAY - 1)) ? '0 : rr_q + 1'b1;
            end
            state_d = TC_MISS_REQ;
          end
        end
      end
      TC_MISS_REQ: begin
        // Request is never retracted, even under flush.
        l2_req_valid_o = 1'b1;
        l2_req_addr_o  = l2_req;
        if (flush_i) drain_d = 1'b1;
        if (l2_req_ready_i) state_d = TC_MISS_WAIT;
      end
      TC_MISS_WAIT: begin
        if (l2_resp_valid_i) begin
          state_d = TC_IDLE;
          drain_d = 1'b0;
          if (!drain_q && !flush_i) begin
            if (l2_resp_err_i) refill_err_o = 1'b1;
            else               state_d      = TC_REFILL_WR;
          end
        end else if (flush_i) begin
          drain_d = 1'b1;
        end
      end
      TC_REFILL_WR: begin
        state_d = TC_IDLE;
        if (!flush_i) begin
          tm_req_o      = victim_q;
          tm_we_o       = 1'b1;
          tm_vbit_o     = 1'b1;
          tm_data_o     = tag_q;
          tm_addr_o     = idx_q;
          refill_done_o = 1'b1;
          refill_way_o  = victim_q;
        end
      end
      default: state_d = TC_IDLE;
    endcase
  end

  // A tag may live in at most one valid way of a set.
  a_single_hit: assert property (@(posedge clk_i) disable iff (!rstn_i)
    (state_q == TC_COMPARE) |-> $onehot0(hitvec));

endmodule

// File: tb/tb_sargantana_icache_tag_ctrl.sv
// Self-checking bench for the I-cache tag controller with a behavioural tag memory and cache model.
// Latency: scripted cycle by cycle per lookup.
// Backpressure: L2 ready/response delays randomised.
module tb_sargantana_icache_tag_ctrl;
  import sargantana_icache_pkg::*;

  localparam int NW = ICACHE_N_WAY;

  logic clk_i = 1'b0;
  logic rstn_i = 1'b0;
  logic flush_i = 1'b1;
  logic lookup_valid_i = 1'b0;
  logic lookup_ready_o;
  logic [TAG_ADDR_WIDHT-1:0] lookup_idx_i = '0;
  logic [TAG_WIDHT-1:0] lookup_tag_i = '0;
  logic hit_o;
  logic [NW-1:0] hit_way_o;
  logic refill_done_o, refill_err_o;
  logic [NW-1:0] refill_way_o;
  logic l2_req_valid_o;
  logic l2_req_ready_i = 1'b0;
  logic [TAG_WIDHT+TAG_ADDR_WIDHT-1:0] l2_req_addr_o;
  logic l2_resp_valid_i = 1'b0;
  logic l2_resp_err_i = 1'b0;
  logic [NW-1:0] tm_req_o;
  logic tm_we_o, tm_vbit_o, tm_flush_o;
  logic [TAG_WIDHT-1:0] tm_data_o;
  logic [TAG_ADDR_WIDHT-1:0] tm_addr_o;
  logic [NW-1:0][TAG_WIDHT-1:0] tm_tag_way_i;
  logic [NW-1:0] tm_vbit_i;

  always #5 clk_i = ~clk_i;

  sargantana_icache_tag_ctrl dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .flush_i(flush_i),
    .lookup_valid_i(lookup_valid_i), .lookup_ready_o(lookup_ready_o),
    .lookup_idx_i(lookup_idx_i), .lookup_tag_i(lookup_tag_i),
    .hit_o(hit_o), .hit_way_o(hit_way_o),
    .refill_done_o(refill_done_o), .refill_err_o(refill_err_o), .refill_way_o(refill_way_o),
    .l2_req_valid_o(l2_req_valid_o), .l2_req_ready_i(l2_req_ready_i), .l2_req_addr_o(l2_req_addr_o),
    .l2_resp_valid_i(l2_resp_valid_i), .l2_resp_err_i(l2_resp_err_i),
    .tm_req_o(tm_req_o), .tm_we_o(tm_we_o), .tm_vbit_o(tm_vbit_o), .tm_flush_o(tm_flush_o),
    .tm_data_o(tm_data_o), .tm_addr_o(tm_addr_o),
    .tm_tag_way_i(tm_tag_way_i), .tm_vbit_i(tm_vbit_i)
  );

  // Tag memory: one-cycle read, write on tm_we_o, flush clears every valid bit.
  logic [TAG_WIDHT-1:0] mem_t [NW][TAG_DEPTH];
  logic                 mem_v [NW][TAG_DEPTH];
  always @(posedge clk_i) begin
    if (tm_flush_o) begin
      for (int w = 0; w < NW; w++)
        for (int s = 0; s < TAG_DEPTH; s++) mem_v[w][s] <= 1'b0;
    end else if (tm_we_o) begin
      for (int w = 0; w < NW; w++)
        if (tm_req_o[w]) begin
          mem_t[w][tm_addr_o] <= tm_data_o;
          mem_v[w][tm_addr_o] <= tm_vbit_o;
        end
    end
    if (|tm_req_o && !tm_we_o) begin
      for (int w = 0; w < NW; w++) begin
        tm_tag_way_i[w] <= mem_t[w][tm_addr_o];
        tm_vbit_i[w]    <= mem_v[w][tm_addr_o];
      end
    end
  end

  // Reference cache contents and replacement pointer.
  logic [TAG_WIDHT-1:0] ref_t [NW][TAG_DEPTH];
  bit                   ref_v [NW][TAG_DEPTH];
  int                   ref_rr;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_ref();
    for (int w = 0; w < NW; w++)
      for (int s = 0; s < TAG_DEPTH; s++) ref_v[w][s] = 1'b0;
  endtask

  // mode: 0 none, 1 flush one cycle in MISS_WAIT, 2 flush held through response,
  //       3 flush one cycle in MISS_REQ, 4 flush in the refill write cycle
  task automatic lookup(input int idx, input int tag, input bit err,
                        input int rdy_dly, input int rsp_dly, input int mode);
    way_oh_t exp_hit, exp_vic;
    bit      flushed, full;
    int      n_wait;
    logic [TAG_ADDR_WIDHT-1:0] ix;
    logic [TAG_WIDHT-1:0]      tg;
    logic [TAG_WIDHT+TAG_ADDR_WIDHT-1:0] exp_addr;
    ix = TAG_ADDR_WIDHT'(idx);
    tg = TAG_WIDHT'(tag);
    exp_addr = {tg, ix};
    flushed = 1'b0;
    exp_hit = '0;
    exp_vic = '0;
    full    = 1'b1;
    for (int w = NW - 1; w >= 0; w--) begin
      if (ref_v[w][ix] && ref_t[w][ix] == tg) exp_hit = way_oh_t'(1) << w;
      if (!ref_v[w][ix]) begin
        exp_vic = way_oh_t'(1) << w;
        full    = 1'b0;
      end
    end

    lookup_valid_i = 1'b1;
    lookup_idx_i   = ix;
    lookup_tag_i   = tg;
    @(negedge clk_i);
    check("accept_ready", lookup_ready_o, 1);
    check("rd_req", tm_req_o, {NW{1'b1}});
    check("rd_we", tm_we_o, 0);
    check("rd_addr", tm_addr_o, ix);
    step();
    lookup_valid_i = 1'b0;
    @(negedge clk_i);
    check("busy_ready", lookup_ready_o, 0);
    check("hit", hit_o, exp_hit != 0);
    if (exp_hit != 0) begin
      check("hit_way", hit_way_o, exp_hit);
      check("hit_no_l2", l2_req_valid_o, 0);
      step();
      return;
    end
    if (full) begin
      exp_vic = way_oh_t'(1) << ref_rr;
      ref_rr  = (ref_rr + 1) % NW;
    end
    step();

    if (mode == 3) begin
      flush_i = 1'b1;
      flushed = 1'b1;
      clear_ref();
    end
    for (int c = 0; c < rdy_dly; c++) begin
      @(negedge clk_i);
      check("l2_vld_hold", l2_req_valid_o, 1);
      check("l2_addr_hold", l2_req_addr_o, exp_addr);
      step();
      flush_i = 1'b0;
    end
    l2_req_ready_i = 1'b1;
    @(negedge clk_i);
    check("l2_vld", l2_req_valid_o, 1);
    check("l2_addr", l2_req_addr_o, exp_addr);
    step();
    l2_req_ready_i = 1'b0;
    flush_i = 1'b0;

    if (mode == 1 || mode == 2) begin
      flush_i = 1'b1;
      flushed = 1'b1;
      clear_ref();
    end
    n_wait = rsp_dly + ((mode == 1) ? 1 : 0);
    for (int c = 0; c < n_wait; c++) begin
      @(negedge clk_i);
      check("wait_no_l2", l2_req_valid_o, 0);
      check("wait_we", tm_we_o, 0);
      if (flush_i) check("tm_flush", tm_flush_o, 1);
      step();
      if (mode == 1) flush_i = 1'b0;
    end
    l2_resp_valid_i = 1'b1;
    l2_resp_err_i   = err;
    @(negedge clk_i);
    check("refill_err", refill_err_o, err && !flushed);
    check("resp_we", tm_we_o, 0);
    step();
    l2_resp_valid_i = 1'b0;
    l2_resp_err_i   = 1'b0;
    flush_i         = 1'b0;

    if (mode == 4 && !flushed && !err) begin
      flush_i = 1'b1;
      clear_ref();
      @(negedge clk_i);
      check("fl_wr_req", tm_req_o, 0);
      check("fl_wr_we", tm_we_o, 0);
      check("fl_wr_done", refill_done_o, 0);
      step();
      flush_i = 1'b0;
      return;
    end
    @(negedge clk_i);
    if (!flushed && !err) begin
      check("wr_req", tm_req_o, exp_vic);
      check("wr_we", tm_we_o, 1);
      check("wr_vbit", tm_vbit_o, 1);
      check("wr_data", tm_data_o, tg);
      check("wr_addr", tm_addr_o, ix);
      check("refill_done", refill_done_o, 1);
      check("refill_way", refill_way_o, exp_vic);
      for (int w = 0; w < NW; w++)
        if (exp_vic[w]) begin
          ref_t[w][ix] = tg;
          ref_v[w][ix] = 1'b1;
        end
    end else begin
      check("drop_we", tm_we_o, 0);
      check("drop_done", refill_done_o, 0);
      check("drop_ready", lookup_ready_o, 1);
    end
    step();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    clear_ref();
    ref_rr = 0;
    // Reset held with flush high: memory cleared, outputs quiet.
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_ready", lookup_ready_o, 0);
    check("rst_tm_flush", tm_flush_o, 1);
    check("rst_l2_vld", l2_req_valid_o, 0);
    check("rst_tm_req", tm_req_o, 0);
    check("rst_hit", hit_o, 0);
    step();
    rstn_i = 1'b1;
    @(negedge clk_i);
    check("flush_idle_ready", lookup_ready_o, 0);
    step();
    flush_i = 1'b0;
    @(negedge clk_i);
    check("idle_ready", lookup_ready_o, 1);
    step();

    // Cold miss then hit on the same line.
    lookup(5, 'h1234, 0, 0, 0, 0);
    lookup(5, 'h1234, 0, 0, 0, 0);

    // Fill a set, then evict round-robin through all ways and wrap.
    for (int i = 0; i < 4; i++) lookup(9, 'hA0 + i, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) lookup(9, 'hB0 + i, 0, 0, 1, 0);
    lookup(9, 'hB4, 0, 0, 0, 0);

    // Long L2 backpressure with error response, then the same line succeeds.
    lookup(20, 'h777, 1, 10, 2, 0);
    lookup(20, 'h777, 0, 0, 0, 0);

    // Flush in each miss phase; previously cached line must miss afterwards.
    lookup(30, 'h55, 0, 0, 3, 1);
    lookup(5, 'h1234, 0, 0, 0, 0);
    lookup(31, 'h56, 0, 2, 1, 2);
    lookup(32, 'h57, 0, 1, 0, 3);
    lookup(33, 'h58, 0, 0, 0, 4);
    lookup(33, 'h58, 0, 0, 0, 0);

    // Async reset while the L2 request is pending.
    lookup_valid_i = 1'b1;
    lookup_idx_i   = TAG_ADDR_WIDHT'(40);
    lookup_tag_i   = TAG_WIDHT'('h9999);
    step();
    lookup_valid_i = 1'b0;
    step();
    @(negedge clk_i);
    check("mr_l2_vld", l2_req_valid_o, 1);
    #2 rstn_i = 1'b0;
    #1;
    check("mr_rst_l2_vld", l2_req_valid_o, 0);
    check("mr_rst_l2_addr", l2_req_addr_o, 0);
    check("mr_rst_ready", lookup_ready_o, 0);
    check("mr_rst_tm_req", tm_req_o, 0);
    ref_rr = 0;
    step();
    rstn_i = 1'b1;
    @(negedge clk_i);
    check("mr_post_ready", lookup_ready_o, 1);
    step();

    // Randomised traffic over a few hot sets and a small tag pool.
    for (int n = 0; n < 150; n++) begin
      int idx, tag, r, mode;
      idx  = ($urandom_range(0, 9) == 0) ? TAG_DEPTH - 1 : $urandom_range(0, 3);
      tag  = 'h100 + $urandom_range(0, 6);
      r    = $urandom_range(0, 19);
      mode = (r < 16) ? 0 : r - 15;
      if ($urandom_range(0, 14) == 0) begin
        flush_i = 1'b1;
        clear_ref();
        @(negedge clk_i);
        check("rnd_flush_ready", lookup_ready_o, 0);
        step();
        flush_i = 1'b0;
      end
      lookup(idx, tag, $urandom_range(0, 7) == 0, $urandom_range(0, 3),
             $urandom_range(0, 3), mode);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
